// File: rtl/fft_addr_seq_if.sv
// Bus between the FFT address sequencer and its frame source / result consumer.
// The slave side is the sequencer; the master side feeds samples and drains results.
interface fft_addr_seq_if #(
   parameter int LOG2N = 9
);
   logic             load_start;
   logic             load_valid;
   logic             out_ready;
   logic [LOG2N-1:0] ram0_addr_a;
   logic [LOG2N-1:0] ram0_addr_b;
   logic [LOG2N-1:0] ram1_addr_a;
   logic [LOG2N-1:0] ram1_addr_b;
   logic             ram0_we;
   logic             ram1_we;
   logic [LOG2N-2:0] tw_addr;
   logic             src_sel;
   logic             out_valid;
   logic [LOG2N-1:0] out_idx;
   logic             busy;
   logic             fft_done;
   logic [15:0]      frame_cnt;

   modport master (
      output load_start, load_valid, out_ready,
      input  ram0_addr_a, ram0_addr_b, ram1_addr_a, ram1_addr_b,
      input  ram0_we, ram1_we, tw_addr, src_sel,
      input  out_valid, out_idx, busy, fft_done, frame_cnt
   );

   modport slave (
      input  load_start, load_valid, out_ready,
      output ram0_addr_a, ram0_addr_b, ram1_addr_a, ram1_addr_b,
      output ram0_we, ram1_we, tw_addr, src_sel,
      output out_valid, out_idx, busy, fft_done, frame_cnt
   );
endinterface

// File: rtl/fft_addr_seq.sv
// Address sequencer for an in-place ping-pong radix-2 FFT.
// Loads a frame into RAM0 in bit-reversed order, runs LOG2N butterfly stages
// alternating RAM0/RAM1 as source and destination, then reads the result RAM
// out in natural order.
module fft_addr_seq #(
   parameter int LOG2N  = 9,
   parameter int BF_LAT = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   fft_addr_seq_if.slave bus
);
   localparam int AW = LOG2N;
   localparam int TW = LOG2N - 1;
   localparam int SW = 4;
   // Result lands in RAM1 when the number of stages is odd.
   localparam bit RES_RAM1 = (LOG2N % 2) == 1;

   localparam logic [AW-1:0] K_LAST  = {AW{1'b1}};
   localparam logic [TW-1:0] BF_LAST = {TW{1'b1}};
   localparam logic [SW-1:0] S_LAST  = SW'(LOG2N - 1);
   localparam logic [3:0]    D_LAST  = 4'(BF_LAT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

   state_t          state;
   logic [AW-1:0]   k;          // load sample counter
   logic [AW-1:0]   j;          // unload address counter
   logic [TW-1:0]   bf;         // butterfly index within stage
   logic [SW-1:0]   stg;        // stage index
   logic [3:0]      dcnt;       // drain cycle counter
   logic [15:0]     frame_cnt_q;
   logic            out_valid_q;
   logic [AW-1:0]   out_idx_q;

   // Butterfly operand addresses for the current (stg, bf).
   logic [AW-1:0]   bf_ext, bit_s, pos, rd_a, rd_b;
   logic [TW-1:0]   tw_val;
   logic            rd_vld;

   // Write-side delay line: read addresses reappear BF_LAT cycles later as
   // destination write addresses.
   logic [BF_LAT:1] vld_pipe;
   logic [AW-1:0]   wa_pipe [1:BF_LAT];
   logic [AW-1:0]   wb_pipe [1:BF_LAT];
   logic            wr_vld;
   logic [AW-1:0]   wr_a, wr_b;

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
      logic [AW-1:0] r;
      for (int n = 0; n < AW; n++) r[n] = v[AW-1-n];
      return r;
   endfunction

   assign rd_vld = (state == COMPUTE);
   assign wr_vld = vld_pipe[BF_LAT];
   assign wr_a   = wa_pipe[BF_LAT];
   assign wr_b   = wb_pipe[BF_LAT];

   // Butterfly address generation: insert a zero bit at position stg of bf.
   always_comb begin
      bf_ext = {1'b0, bf};
      bit_s  = AW'(1) << stg;
      pos    = bf_ext & (bit_s - AW'(1));
      rd_a   = ((bf_ext >> stg) << (stg + SW'(1))) | pos;
      rd_b   = rd_a | bit_s;
      tw_val = TW'(pos << (S_LAST - stg));
   end

   // Delay line carrying read addresses to the write side; cleared on reset so
   // no write survives an abort.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         for (int p = 1; p <= BF_LAT; p++) begin
            wa_pipe[p] <= '0;
            wb_pipe[p] <= '0;
         end
      end else begin
         vld_pipe[1] <= rd_vld;
         wa_pipe[1]  <= rd_a;
         wb_pipe[1]  <= rd_b;
         for (int p = 2; p <= BF_LAT; p++) begin
            vld_pipe[p] <= vld_pipe[p-1];
            wa_pipe[p]  <= wa_pipe[p-1];
            wb_pipe[p]  <= wb_pipe[p-1];
         end
      end
   end

   // Frame sequencing FSM with its counters and registered result outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         k           <= '0;
         j           <= '0;
         bf          <= '0;
         stg         <= '0;
         dcnt        <= '0;
         frame_cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load_start) begin
                  state <= LOAD;
                  k     <= '0;
               end
            end
            LOAD: begin
               if (bus.load_valid) begin
                  k <= k + AW'(1);
                  if (k == K_LAST) begin
                     state <= COMPUTE;
                     bf    <= '0;
                     stg   <= '0;
                  end
               end
            end
            COMPUTE: begin
               bf <= bf + TW'(1);
               if (bf == BF_LAST) begin
                  state <= DRAIN;
                  dcnt  <= '0;
               end
            end
            DRAIN: begin
               dcnt <= dcnt + 4'd1;
               // Last write of the stage happens in the final drain cycle.
               if (dcnt == D_LAST) begin
                  dcnt <= '0;
                  if (stg == S_LAST) begin
                     state <= UNLOAD;
                     j     <= '0;
                  end else begin
                     stg   <= stg + SW'(1);
                     bf    <= '0;
                     state <= COMPUTE;
                  end
               end
            end
            UNLOAD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b1;
                  out_idx_q   <= j;
                  j           <= j + AW'(1);
                  if (j == K_LAST) begin
                     state       <= IDLE;
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RAM port steering: src_sel picks which RAM reads operands and which
   // takes the delayed writes; everything idles at zero.
   always_comb begin
      bus.ram0_addr_a = '0;
      bus.ram0_addr_b = '0;
      bus.ram1_addr_a = '0;
      bus.ram1_addr_b = '0;
      bus.ram0_we     = 1'b0;
      bus.ram1_we     = 1'b0;
      bus.tw_addr     = '0;
      bus.src_sel     = 1'b0;
      bus.fft_done    = 1'b0;
      case (state)
         LOAD: begin
            bus.ram0_addr_a = bitrev(k);
            bus.ram0_we     = bus.load_valid;
         end
         COMPUTE, DRAIN: begin
            bus.src_sel = stg[0];
            bus.tw_addr = rd_vld ? tw_val : '0;
            if (!stg[0]) begin
               bus.ram0_addr_a = rd_vld ? rd_a : '0;
               bus.ram0_addr_b = rd_vld ? rd_b : '0;
               bus.ram1_addr_a = wr_vld ? wr_a : '0;
               bus.ram1_addr_b = wr_vld ? wr_b : '0;
               bus.ram1_we     = wr_vld;
            end else begin
               bus.ram1_addr_a = rd_vld ? rd_a : '0;
               bus.ram1_addr_b = rd_vld ? rd_b : '0;
               bus.ram0_addr_a = wr_vld ? wr_a : '0;
               bus.ram0_addr_b = wr_vld ? wr_b : '0;
               bus.ram0_we     = wr_vld;
            end
         end
         UNLOAD: begin
            if (RES_RAM1) bus.ram1_addr_a = j;
            else          bus.ram0_addr_a = j;
            bus.fft_done = bus.out_ready && (j == K_LAST);
         end
         default: ;
      endcase
   end

   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_addr_seq.sv
// Directed bench for fft_addr_seq: an 8-point / BF_LAT=2 instance checked cycle
// by cycle against hand tables, plus a 16-point instance for frame timing.
module tb_fft_addr_seq;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   fft_addr_seq_if #(.LOG2N(3)) b3();
   fft_addr_seq_if #(.LOG2N(4)) b4();

   fft_addr_seq #(.LOG2N(3), .BF_LAT(2)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3));
   fft_addr_seq #(.LOG2N(4), .BF_LAT(2)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b4));

   int brv  [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
   int brv4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
   int ra   [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
   int rb   [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
   int twt  [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic start3();
      b3.load_start = 1'b1;
      nxt();
      b3.load_start = 1'b0;
   endtask

   task automatic load3(input bit gap);
      int n;
      int cyc;
      n = 0;
      cyc = 0;
      while (n < 8 && cyc < 40) begin
         b3.load_valid = gap ? (cyc[0] == 1'b0) : 1'b1;
         mid();
         if (b3.load_valid) begin
            chk("load_we", b3.ram0_we, 1);
            chk("load_addr", b3.ram0_addr_a, brv[n]);
            n++;
         end else begin
            chk("load_gap_we", b3.ram0_we, 0);
         end
         chk("load_r1we", b3.ram1_we, 0);
         nxt();
         cyc++;
      end
      b3.load_valid = 1'b0;
      if (n < 8) chk("load_timeout", n, 8);
   endtask

   task automatic compute3(input bit rst_mid);
      for (int c = 0; c < 18; c++) begin
         int st;
         int w;
         int sel;
         logic [31:0] sa, sb, da, db, swe, dwe;
         st  = c / 6;
         w   = c % 6;
         sel = st % 2;
         b3.load_start = (c == 1);
         b3.out_ready  = (c % 2 == 1);
         if (rst_mid && c == 8) begin
            b3.load_start = 1'b0;
            reset_n = 1'b0;
            mid();
            chk("rst_busy", b3.busy, 0);
            chk("rst_r0we", b3.ram0_we, 0);
            chk("rst_r1we", b3.ram1_we, 0);
            chk("rst_fcnt", b3.frame_cnt, 0);
            nxt();
            reset_n = 1'b1;
            return;
         end
         mid();
         sa  = sel ? b3.ram1_addr_a : b3.ram0_addr_a;
         sb  = sel ? b3.ram1_addr_b : b3.ram0_addr_b;
         da  = sel ? b3.ram0_addr_a : b3.ram1_addr_a;
         db  = sel ? b3.ram0_addr_b : b3.ram1_addr_b;
         swe = sel ? b3.ram1_we : b3.ram0_we;
         dwe = sel ? b3.ram0_we : b3.ram1_we;
         chk("cmp_busy", b3.busy, 1);
         chk("src_sel", b3.src_sel, sel);
         chk("src_we", swe, 0);
         if (w < 4) begin
            chk("rd_a", sa, ra[st*4 + w]);
            chk("rd_b", sb, rb[st*4 + w]);
            chk("tw", b3.tw_addr, twt[st*4 + w]);
         end
         if (w >= 2) begin
            chk("wr_we", dwe, 1);
            chk("wr_a", da, ra[st*4 + w - 2]);
            chk("wr_b", db, rb[st*4 + w - 2]);
         end else begin
            chk("wr_idle_we", dwe, 0);
         end
         nxt();
      end
      b3.load_start = 1'b0;
   endtask

   task automatic unload3(input int fc);
      int j;
      int pend;
      int pj;
      int dn;
      int cyc;
      j = 0; pend = 0; pj = 0; dn = 0; cyc = 0;
      while (j < 8 && cyc < 30) begin
         b3.out_ready = !(cyc == 1 || cyc == 5);
         mid();
         chk("un_busy", b3.busy, 1);
         chk("un_addr", b3.ram1_addr_a, j);
         chk("un_we", b3.ram0_we | b3.ram1_we, 0);
         chk("un_vld", b3.out_valid, pend);
         if (pend != 0) chk("un_idx", b3.out_idx, pj);
         chk("un_done", b3.fft_done, (b3.out_ready && j == 7));
         chk("un_fcnt", b3.frame_cnt, fc);
         if (b3.fft_done) dn++;
         pend = b3.out_ready;
         pj = j;
         if (b3.out_ready) j++;
         nxt();
         cyc++;
      end
      b3.out_ready = 1'b0;
      if (j < 8) chk("un_timeout", j, 8);
      mid();
      chk("end_busy", b3.busy, 0);
      chk("end_vld", b3.out_valid, 1);
      chk("end_idx", b3.out_idx, 7);
      chk("end_fcnt", b3.frame_cnt, fc + 1);
      chk("end_done", b3.fft_done, 0);
      chk("end_addr", b3.ram1_addr_a, 0);
      chk("done_cnt", dn, 1);
      nxt();
      mid();
      chk("end_vld_off", b3.out_valid, 0);
      nxt();
   endtask

   initial begin
      b3.load_start = 1'b0; b3.load_valid = 1'b0; b3.out_ready = 1'b0;
      b4.load_start = 1'b0; b4.load_valid = 1'b0; b4.out_ready = 1'b0;
      repeat (2) nxt();
      mid();
      chk("rst_busy0", b3.busy, 0);
      chk("rst_fcnt0", b3.frame_cnt, 0);
      chk("rst_we0", b3.ram0_we | b3.ram1_we, 0);
      chk("rst_vld0", b3.out_valid, 0);
      chk("rst_addr0", b3.ram0_addr_a, 0);
      chk("rst_tw0", b3.tw_addr, 0);
      chk("rst_sel0", b3.src_sel, 0);
      nxt();
      reset_n = 1'b1;
      b3.load_valid = 1'b1;
      b3.out_ready = 1'b1;
      mid();
      chk("idle_lv_we", b3.ram0_we, 0);
      chk("idle_busy", b3.busy, 0);
      nxt();
      b3.load_valid = 1'b0;
      b3.out_ready = 1'b0;

      // Frame 1: gapped load, full compute, stalled unload.
      start3();
      load3(1'b1);
      compute3(1'b0);
      unload3(0);

      // Frame 2: aborted by reset during stage 1.
      start3();
      load3(1'b0);
      compute3(1'b1);
      mid();
      chk("post_rst_busy", b3.busy, 0);
      chk("post_rst_fcnt", b3.frame_cnt, 0);
      chk("post_rst_we", b3.ram0_we | b3.ram1_we, 0);
      nxt();

      // Frame 3: fresh frame after the abort.
      start3();
      load3(1'b0);
      compute3(1'b0);
      unload3(0);

      // 16-point instance: load, compute length, write counts, unload.
      begin
         int c;
         int w0;
         int w1;
         int nv;
         b4.load_start = 1'b1;
         nxt();
         b4.load_start = 1'b0;
         b4.load_valid = 1'b1;
         for (int n = 0; n < 16; n++) begin
            mid();
            chk("l4_addr", b4.ram0_addr_a, brv4[n]);
            nxt();
         end
         b4.load_valid = 1'b0;
         b4.out_ready = 1'b1;
         c = 0; w0 = 0; w1 = 0;
         while (c < 200) begin
            mid();
            if (b4.out_valid) break;
            w0 += int'(b4.ram0_we);
            w1 += int'(b4.ram1_we);
            c++;
            nxt();
         end
         chk("c4_len", c, 41);
         chk("c4_w0", w0, 16);
         chk("c4_w1", w1, 16);
         nv = 0;
         for (int t = 0; t < 40; t++) begin
            if (!b4.out_valid) break;
            chk("u4_idx", b4.out_idx, nv);
            nv++;
            nxt();
            mid();
         end
         chk("u4_cnt", nv, 16);
         chk("u4_busy", b4.busy, 0);
         chk("u4_fcnt", b4.frame_cnt, 1);
         b4.out_ready = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
